alu_issue_ctrl: RTL and testbench

Issue-side controller for the 64-bit datapath ALU. It accepts decoded instruction fields and operands over a valid/ready handshake and translates the 2-bit ALUOp plus the 11-bit instruction opcode into the ALU's 4-bit control code. It drives registered operands into the combinational ALU, captures the result and a locally computed zero flag, and returns them over a second valid/ready handshake. It sits between the decode stage and the ALU, and owns all ALU control encoding.

---
 rtl/alu_issue_ctrl_if.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and response signal bundle for alu_issue_ctrl.
// slave is the controller; master is the decode/ALU/consumer side.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [10:0]      in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] alu_input1;
  logic [WIDTH-1:0] alu_input2;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_err;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, in_aluop, in_opcode,
    input  in_a, in_b, alu_result, out_ready,
    output in_ready, alu_input1, alu_input2,
    output alu_opcode, out_valid, out_result,
    output out_zero, out_err, op_count
  );

  modport master (
    output in_valid, in_aluop, in_opcode,
    output in_a, in_b, alu_result, out_ready,
    input  in_ready, alu_input1, alu_input2,
    input  alu_opcode, out_valid, out_result,
    input  out_zero, out_err, op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ALUOp/opcode, drives registered
// operands into the ALU and returns the captured result.
module alu_issue_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst_n,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             lerr_q, lerr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dec_op;
  logic             dec_err;

  always_comb begin
    dec_op  = 4'b1111;
    dec_err = 1'b0;
    unique case (1'b1)
      (bus.in_aluop == 2'b00): dec_op = 4'b0010;
      (bus.in_aluop == 2'b01): dec_op = 4'b0111;
      (bus.in_aluop == 2'b11): dec_op = 4'b1100;
      default: begin
        unique case (bus.in_opcode)
          11'b10001011000: dec_op = 4'b0010;
          11'b11001011000: dec_op = 4'b0110;
          11'b10001010000: dec_op = 4'b0000;
          11'b10101010000: dec_op = 4'b0001;
          default: begin
            dec_op  = 4'b1111;
            dec_err = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    err_d       = err_q;
    lerr_d      = lerr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        // in_ready_q gates accept so none happens in the first cycle after reset
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.in_a;
          b_d        = bus.in_b;
          op_d       = dec_op;
          lerr_d     = dec_err;
          in_ready_d = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d       = bus.alu_result;
        zero_d      = (bus.alu_result == '0);
        err_d       = lerr_q;
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + 1'b1;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      lerr_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 4'b0000;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      lerr_q      <= lerr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_err    = err_q;
  assign bus.alu_input1 = a_q;
  assign bus.alu_input2 = b_q;
  assign bus.alu_opcode = op_q;
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed vector bench for alu_issue_ctrl with a behavioural ALU.
// A narrow op_count makes the wrap reachable in a short run.
module tb_alu_issue_ctrl;
  localparam int W  = 64;
  localparam int CW = 3;

  typedef struct {
    logic [1:0]  aluop;
    logic [10:0] opc;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  code;
    logic [63:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [CW-1:0] exp_cnt;
  vec_t vt[8];

  alu_issue_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_opcode)
      4'b0010: bus.alu_result = bus.alu_input1 + bus.alu_input2;
      4'b0110: bus.alu_result = bus.alu_input1 - bus.alu_input2;
      4'b0000: bus.alu_result = bus.alu_input1 & bus.alu_input2;
      4'b0001: bus.alu_result = bus.alu_input1 | bus.alu_input2;
      4'b0111: bus.alu_result = bus.alu_input2;
      4'b1100: bus.alu_result = ~(bus.alu_input1 | bus.alu_input2);
      default: bus.alu_result = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && bus.in_ready !== 1'b1; i++)
      @(negedge clk);
    chk("accept_wait", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic send(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_aluop  = v.aluop;
    bus.in_opcode = v.opc;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    bus.out_ready = 1'b1;
    send(v);
    wait_ready();
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({s, "_code"}, {60'd0, bus.alu_opcode}, {60'd0, v.code});
    chk({s, "_rdy_exec"}, {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    chk({s, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({s, "_res"}, bus.out_result, v.res);
    chk({s, "_zero"}, {63'd0, bus.out_zero}, {63'd0, v.zero});
    chk({s, "_err"}, {63'd0, bus.out_err}, {63'd0, v.err});
    @(negedge clk);
    exp_cnt++;
    chk({s, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
    chk({s, "_cnt"}, {61'd0, bus.op_count}, {61'd0, exp_cnt});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  initial begin
    vec_t bp1, bp2;
    clk   = 1'b0;
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.in_aluop  = 2'b00;
    bus.in_opcode = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    vt[0] = '{2'b10, 11'b10001011000, 64'd5, 64'd7,
              4'b0010, 64'd12, 1'b0, 1'b0};
    vt[1] = '{2'b10, 11'b11001011000, '1, '1,
              4'b0110, 64'd0, 1'b1, 1'b0};
    vt[2] = '{2'b01, 11'b11111111111, 64'h55, 64'd0,
              4'b0111, 64'd0, 1'b1, 1'b0};
    vt[3] = '{2'b00, 11'b11001011000, 64'h100, 64'h8,
              4'b0010, 64'h108, 1'b0, 1'b0};
    vt[4] = '{2'b10, 11'b11111111111, 64'd9, 64'd4,
              4'b1111, 64'd0, 1'b1, 1'b1};
    vt[5] = '{2'b10, 11'b10101010000, 64'hF0, 64'h0F,
              4'b0001, 64'hFF, 1'b0, 1'b0};
    vt[6] = '{2'b11, 11'b10001011000, 64'd0, 64'd0,
              4'b1100, '1, 1'b0, 1'b0};
    vt[7] = '{2'b10, 11'b10001010000, 64'hFF00, 64'h0FF0,
              4'b0000, 64'h0F00, 1'b0, 1'b0};

    rst_n = 1'b0;
    #2;
    chk("rst_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_res", bus.out_result, 64'd0);
    chk("rst_zero", {63'd0, bus.out_zero}, 64'd0);
    chk("rst_err", {63'd0, bus.out_err}, 64'd0);
    chk("rst_cnt", {61'd0, bus.op_count}, 64'd0);
    chk("rst_in1", bus.alu_input1, 64'd0);
    chk("rst_in2", bus.alu_input2, 64'd0);
    chk("rst_code", {60'd0, bus.alu_opcode}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    chk("rel_ready_low", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    chk("rel_ready_high", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);
    chk("wrap_cnt", {61'd0, bus.op_count}, 64'd0);

    bp1 = '{2'b10, 11'b10001010000, 64'hF0, 64'h3C,
            4'b0000, 64'h30, 1'b0, 1'b0};
    bp2 = '{2'b10, 11'b10001011000, 64'd1, 64'd2,
            4'b0010, 64'd3, 1'b0, 1'b0};
    bus.out_ready = 1'b0;
    send(bp1);
    wait_ready();
    @(negedge clk);
    send(bp2);
    chk("bp_code", {60'd0, bus.alu_opcode}, 64'b0000);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_res", bus.out_result, 64'h30);
      chk("bp_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    chk("bp_hs_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("bp_hs_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_no_early", {60'd0, bus.alu_opcode}, 64'b0000);
    chk("bp_cnt1", {61'd0, bus.op_count}, {61'd0, exp_cnt});
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp2_code", {60'd0, bus.alu_opcode}, 64'b0010);
    chk("bp2_in1", bus.alu_input1, 64'd1);
    @(negedge clk);
    chk("bp2_res", bus.out_result, 64'd3);
    @(negedge clk);
    exp_cnt++;
    chk("bp2_cnt", {61'd0, bus.op_count}, {61'd0, exp_cnt});

    run_vec(vt[3], 8);
    chk("pre_rst_cnt", {61'd0, bus.op_count}, 64'd3);
    bus.out_ready = 1'b0;
    send(vt[5]);
    wait_ready();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_valid", {63'd0, bus.out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_cnt", {61'd0, bus.op_count}, 64'd0);
    chk("mid_rst_code", {60'd0, bus.alu_opcode}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("mid_rel_valid", {63'd0, bus.out_valid}, 64'd0);
    exp_cnt = '0;
    run_vec(vt[0], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
